// File: rtl/stimulus_sequencer_pkg.sv
// Shared constants and state encoding for the latency tester stimulus sequencer.
// Defaults are derived from the 27 MHz board clock and its divider ratios.
package stimulus_sequencer_pkg;

  localparam int CLOCK_HZ              = 27000000;
  localparam int CLOCK_DIVIDER_PERIOD  = 4;
  localparam int CLOCK_DIVIDER_TIMEOUT = 5;

  localparam int DEFAULT_PERIOD_CYCLES   = CLOCK_HZ / CLOCK_DIVIDER_PERIOD;
  localparam int DEFAULT_TIMEOUT_CYCLES  = CLOCK_HZ / CLOCK_DIVIDER_TIMEOUT;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 270;
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_CFG_WIDTH       = 8;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_FLASH_ENC = 2'd1;
  localparam logic [1:0] ST_DARK_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_FLASH = ST_FLASH_ENC,
    ST_DARK  = ST_DARK_ENC
  } seq_state_t;

endpackage

// File: rtl/stimulus_sequencer_if.sv
// Pin-side bundle of the stimulus sequencer: operator/sensor inputs and control strobes.
interface stimulus_sequencer_if #(
  parameter int CFG_WIDTH = 8
);
  // Levels: enable, config_data, sensor_input, flash_on, busy. Every other output
  // is a single-cycle strobe with no handshake; consumers must sample every cycle.
  logic                 enable;
  logic [CFG_WIDTH-1:0] config_data;
  logic                 sensor_input;
  logic                 flash_on;
  logic                 reset_counter;
  logic                 sensor_trigger;
  logic                 reset_bcdoutput;
  logic                 timeout;
  logic                 busy;

  modport master (
    output enable, config_data, sensor_input,
    input  flash_on, reset_counter, sensor_trigger, reset_bcdoutput, timeout, busy
  );

  modport slave (
    input  enable, config_data, sensor_input,
    output flash_on, reset_counter, sensor_trigger, reset_bcdoutput, timeout, busy
  );
endinterface

// File: rtl/stimulus_sequencer_sensor_debounce.sv
// Photo-sensor conditioning: flop synchronizer followed by a consecutive-sample
// debouncer. rise is a registered one-cycle pulse aligned with the level going high.
module sensor_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 270
) (
  input  logic clock,
  input  logic reset_bcdcounter,
  input  logic sensor_input,
  output logic level,
  output logic rise
);
  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          db_cnt;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge reset_bcdcounter) begin
    if (reset_bcdcounter) begin
      sync_q <= '0;
      db_cnt <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sensor_input};
      rise   <= 1'b0;
      // Any sample that agrees with the current level restarts the stability run.
      if (synced == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level  <= synced;
        rise   <= synced;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stimulus_sequencer.sv
// Periodic flash stimulus and measurement strobes for the latency tester.
// A config change forces a full dark guard period before the next flash.
module stimulus_sequencer
  import stimulus_sequencer_pkg::*;
#(
  parameter int PERIOD_CYCLES   = DEFAULT_PERIOD_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int CFG_WIDTH       = DEFAULT_CFG_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset_bcdcounter,
  stimulus_sequencer_if.slave  bus,
  output seq_state_t           state_dbg
);
  localparam int            PW     = $clog2(PERIOD_CYCLES);
  localparam logic [PW-1:0] P_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [PW-1:0] T_LAST = PW'(TIMEOUT_CYCLES - 1);

  seq_state_t           state_q, state_d;
  logic [PW-1:0]        pcnt_q, pcnt_d;
  logic [CFG_WIDTH-1:0] cfg_q;
  logic                 level, rise, cfg_chg;
  logic                 flash_d, rc_d, trig_d, bcd_d, to_d;

  sensor_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sensor_debounce (
    .clock            (clock),
    .reset_bcdcounter (reset_bcdcounter),
    .sensor_input     (bus.sensor_input),
    .level            (level),
    .rise             (rise)
  );

  assign cfg_chg   = (bus.config_data != cfg_q);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    flash_d = 1'b0;
    rc_d    = 1'b0;
    trig_d  = 1'b0;
    bcd_d   = 1'b0;
    to_d    = 1'b0;
    // Config change outranks every other event, including a same-cycle rise or timeout.
    if (cfg_chg) begin
      state_d = ST_DARK;
      pcnt_d  = '0;
      bcd_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.enable) begin
            state_d = ST_FLASH;
            pcnt_d  = '0;
            rc_d    = 1'b1;
            flash_d = 1'b1;
          end
        end
        ST_FLASH: begin
          pcnt_d = pcnt_q + PW'(1);
          if (rise) begin
            trig_d  = 1'b1;
            state_d = ST_DARK;
          end else if (pcnt_q == T_LAST) begin
            to_d    = 1'b1;
            state_d = ST_DARK;
          end else begin
            flash_d = 1'b1;
          end
        end
        ST_DARK: begin
          // The counter parks at P_LAST while a still-lit sensor stretches the period.
          if (pcnt_q < P_LAST) begin
            pcnt_d = pcnt_q + PW'(1);
          end else if (!level) begin
            pcnt_d = '0;
            if (bus.enable) begin
              state_d = ST_FLASH;
              rc_d    = 1'b1;
              flash_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset_bcdcounter) begin
    if (reset_bcdcounter) begin
      state_q             <= ST_IDLE;
      pcnt_q              <= '0;
      cfg_q               <= '0;
      bus.flash_on        <= 1'b0;
      bus.reset_counter   <= 1'b0;
      bus.sensor_trigger  <= 1'b0;
      bus.reset_bcdoutput <= 1'b0;
      bus.timeout         <= 1'b0;
      bus.busy            <= 1'b0;
    end else begin
      state_q             <= state_d;
      pcnt_q              <= pcnt_d;
      cfg_q               <= bus.config_data;
      bus.flash_on        <= flash_d;
      bus.reset_counter   <= rc_d;
      bus.sensor_trigger  <= trig_d;
      bus.reset_bcdoutput <= bcd_d;
      bus.timeout         <= to_d;
      bus.busy            <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_stimulus_sequencer.sv
// Bench for stimulus_sequencer: directed period scenarios followed by random
// sensor/enable/config traffic, checked cycle by cycle against a timestamp model.
module tb_stimulus_sequencer;
  import stimulus_sequencer_pkg::*;

  localparam int P  = 100;
  localparam int T  = 60;
  localparam int D  = 3;
  localparam int S  = 2;
  localparam int CW = 8;
  localparam int W  = 8;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset_bcdcounter = 1'b1;
  seq_state_t state_dbg;

  always #5 clock = ~clock;

  stimulus_sequencer_if #(.CFG_WIDTH(CW)) bus();

  stimulus_sequencer #(
    .PERIOD_CYCLES   (P),
    .TIMEOUT_CYCLES  (T),
    .DEBOUNCE_CYCLES (D),
    .SYNC_STAGES     (S),
    .CFG_WIDTH       (CW)
  ) dut (
    .clock            (clock),
    .reset_bcdcounter (reset_bcdcounter),
    .bus              (bus),
    .state_dbg        (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  int edge_n = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // {state, flash_on, reset_counter, sensor_trigger, reset_bcdoutput, timeout, busy}
  function automatic logic [W-1:0] dut_vec();
    return {2'(state_dbg), bus.flash_on, bus.reset_counter, bus.sensor_trigger,
            bus.reset_bcdoutput, bus.timeout, bus.busy};
  endfunction

  // ---------------- reference model ----------------
  // Time-stamp view: a period starts at edge start_e; its age is edges since then.
  int           start_e = 0;
  int           flash_edge = -1000;
  bit           m_running, m_armed, m_level, m_rise;
  int           m_run;
  logic [CW-1:0] m_cfg;
  bit           pin_hist[$];

  task automatic model_reset();
    m_running = 1'b0;
    m_armed   = 1'b0;
    m_level   = 1'b0;
    m_rise    = 1'b0;
    m_run     = 0;
    m_cfg     = '0;
    start_e   = edge_n;
    pin_hist.delete();
    for (int i = 0; i < S; i++) pin_hist.push_back(1'b0);
    exp_q.delete();
  endtask

  // Predicts the outputs just after the next rising edge, given the inputs it samples.
  task automatic model_step(input bit en, input logic [CW-1:0] cfg, input bit sen);
    bit         s_prev, lvl_prev, rise_prev;
    bit         fo, rc, st, rb, to;
    int         age;
    logic [1:0] stv;
    edge_n++;
    s_prev = pin_hist.pop_front();
    pin_hist.push_back(sen);
    lvl_prev  = m_level;
    rise_prev = m_rise;
    age = edge_n - 1 - start_e;
    if (age > P - 1) age = P - 1;
    {fo, rc, st, rb, to} = '0;
    if (cfg != m_cfg) begin
      rb = 1'b1; m_running = 1'b1; m_armed = 1'b0; start_e = edge_n;
    end else if (!m_running) begin
      if (en) begin
        m_running = 1'b1; m_armed = 1'b1; start_e = edge_n; flash_edge = edge_n;
        rc = 1'b1; fo = 1'b1;
      end
    end else if (m_armed) begin
      if (rise_prev) begin
        st = 1'b1; m_armed = 1'b0;
      end else if (age == T - 1) begin
        to = 1'b1; m_armed = 1'b0;
      end else begin
        fo = 1'b1;
      end
    end else if (age >= P - 1 && !lvl_prev) begin
      if (en) begin
        m_armed = 1'b1; start_e = edge_n; flash_edge = edge_n;
        rc = 1'b1; fo = 1'b1;
      end else begin
        m_running = 1'b0;
      end
    end
    m_cfg = cfg;
    m_rise = 1'b0;
    if (s_prev != m_level) begin
      m_run++;
      if (m_run == D) begin
        m_level = s_prev; m_rise = s_prev; m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    stv = !m_running ? ST_IDLE : (m_armed ? ST_FLASH : ST_DARK);
    exp_q.push_back({stv, fo, rc, st, rb, to, m_running});
  endtask

  // ---------------- observation ----------------
  int obs_rc = -1, obs_to = -1, obs_trig = -1, obs_bcd = -1;
  int n_rc = 0, n_to = 0, n_trig = 0;

  task automatic observe();
    if (bus.reset_counter)   begin obs_rc = edge_n;   n_rc++;   end
    if (bus.timeout)         begin obs_to = edge_n;   n_to++;   end
    if (bus.sensor_trigger)  begin obs_trig = edge_n; n_trig++; end
    if (bus.reset_bcdoutput) obs_bcd = edge_n;
  endtask

  // ---------------- driver tasks ----------------
  logic [CW-1:0] cur_cfg = '0;

  task automatic compare_pending();
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("outputs", 32'(dut_vec()), 32'(e));
    end
  endtask

  task automatic cycle(input bit en, input logic [CW-1:0] cfg, input bit sen);
    @(negedge clock);
    compare_pending();
    observe();
    bus.enable       = en;
    bus.config_data  = cfg;
    bus.sensor_input = sen;
    model_step(en, cfg, sen);
  endtask

  task automatic assert_reset();
    @(negedge clock);
    compare_pending();
    reset_bcdcounter = 1'b1;
    model_reset();
  endtask

  task automatic release_reset(input bit en, input logic [CW-1:0] cfg, input bit sen);
    @(negedge clock);
    check("reset_state", 32'(dut_vec()), 32'd0);
    reset_bcdcounter = 1'b0;
    cur_cfg          = cfg;
    bus.enable       = en;
    bus.config_data  = cfg;
    bus.sensor_input = sen;
    model_step(en, cfg, sen);
  endtask

  task automatic wait_flash();
    for (int i = 0; i < 400 && edge_n != flash_edge; i++) cycle(1'b1, cur_cfg, 1'b0);
    if (edge_n != flash_edge) check("wait_flash", 32'd0, 32'd1);
  endtask

  // Drives one period relative to its flash edge: sensor lit in [lit_from, lit_to),
  // an optional 2-cycle glitch, and an optional config write at cycle cfg_at.
  task automatic run_period(input int lit_from, input int lit_to, input int glitch_at,
                            input int cfg_at, input logic [CW-1:0] cfg_val, input int n);
    int f0, c;
    bit sen;
    f0 = flash_edge;
    c  = edge_n - f0;
    while (c < n) begin
      sen = (c >= lit_from && c < lit_to) || (c >= glitch_at && c < glitch_at + 2);
      if (c == cfg_at) cur_cfg = cfg_val;
      cycle(1'b1, cur_cfg, sen);
      c = edge_n - f0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int f, t0, to0, rc0, e_rel, hold;
    bit sen_r, en_r;
    bus.enable       = 1'b0;
    bus.config_data  = '0;
    bus.sensor_input = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);

    // Free-running periods with a dark sensor end in timeouts.
    release_reset(1'b1, 8'h00, 1'b0);
    wait_flash();
    f = flash_edge;
    run_period(-10, -10, -10, -1, 8'h00, 101);
    check("s1_timeout_cycle", 32'(obs_to - f), 32'(T));
    check("s1_next_flash", 32'(obs_rc - f), 32'(P));

    // Clean rise mid-flash.
    wait_flash();
    f = flash_edge; t0 = n_trig; to0 = n_to;
    run_period(20, 41, -10, -1, 8'h00, 101);
    check("s2_latency", 32'(obs_trig - f - 20), 32'(S + D + 1));
    check("s2_no_timeout", 32'(n_to - to0), 32'd0);
    check("s2_next_flash", 32'(obs_rc - f), 32'(P));

    // Short glitch is filtered, clean rise afterwards triggers once.
    wait_flash();
    f = flash_edge; t0 = n_trig;
    run_period(30, 45, 10, -1, 8'h00, 101);
    check("s3_single_trigger", 32'(n_trig - t0), 32'd1);
    check("s3_latency", 32'(obs_trig - f - 30), 32'(S + D + 1));

    // Rise landing on the last flash cycle beats the timeout.
    wait_flash();
    f = flash_edge; t0 = n_trig; to0 = n_to;
    run_period(54, 70, -10, -1, 8'h00, 101);
    check("edge_rise_wins", 32'(n_trig - t0), 32'd1);
    check("edge_rise_wins_no_to", 32'(n_to - to0), 32'd0);
    check("edge_rise_cycle", 32'(obs_trig - f), 32'(T));

    // One cycle later the flash has already timed out; the rise is ignored.
    wait_flash();
    f = flash_edge; t0 = n_trig; to0 = n_to;
    run_period(55, 70, -10, -1, 8'h00, 101);
    check("edge_late_rise_to", 32'(n_to - to0), 32'd1);
    check("edge_late_rise_no_trig", 32'(n_trig - t0), 32'd0);

    // Sensor still lit at period end stretches the dark phase.
    wait_flash();
    f = flash_edge;
    run_period(20, 130, -10, -1, 8'h00, 137);
    check("s4_stretched_flash", 32'(obs_rc - f), 32'(130 + S + D + 1));
    f = flash_edge; to0 = n_to;
    repeat (T + 2) cycle(1'b1, cur_cfg, 1'b0);
    check("s4_follow_timeout", 32'(n_to - to0), 32'd1);
    check("s4_follow_to_cycle", 32'(obs_to - f), 32'(T));

    // Config change in the cycle the internal rise is presented.
    wait_flash();
    f = flash_edge; t0 = n_trig;
    run_period(20, 41, -10, 25, 8'h05, 127);
    check("s5_bcd_cycle", 32'(obs_bcd - f), 32'(26));
    check("s5_no_trigger", 32'(n_trig - t0), 32'd0);
    check("s5_guard_period", 32'(obs_rc - obs_bcd), 32'(P));

    // Asynchronous reset in the middle of a flash.
    wait_flash();
    repeat (30) cycle(1'b1, cur_cfg, 1'b0);
    @(posedge clock);
    #2;
    reset_bcdcounter = 1'b1;
    #1;
    check("s6_async_zero", 32'(dut_vec()), 32'd0);
    model_reset();
    repeat (3) @(negedge clock);
    rc0 = n_rc;
    release_reset(1'b0, 8'h00, 1'b0);
    repeat (30) cycle(1'b0, 8'h00, 1'b0);
    check("s6_idle_busy", 32'(bus.busy), 32'd0);
    check("s6_no_flash", 32'(n_rc - rc0), 32'd0);

    // Nonzero config at reset release produces a reset_bcdoutput pulse.
    assert_reset();
    repeat (2) @(negedge clock);
    release_reset(1'b1, 8'h5A, 1'b0);
    e_rel = edge_n;
    cycle(1'b1, cur_cfg, 1'b0);
    check("cfg_at_release", 32'(obs_bcd), 32'(e_rel));

    // Random traffic.
    hold = 0; sen_r = 1'b0; en_r = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        sen_r = 1'($urandom_range(0, 1));
        hold  = $urandom_range(1, 40);
      end
      hold--;
      if ($urandom_range(0, 199) == 0) en_r = ~en_r;
      if ($urandom_range(0, 299) == 0) cur_cfg = CW'($urandom);
      cycle(en_r, cur_cfg, sen_r);
    end
    @(negedge clock);
    compare_pending();

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
